// File: rtl/patr_gen_pkg.sv
// Shared types and constants for the Patr pattern checker and its stimulus generator.
package definitions;

  localparam int PATR_NUM_POS = 5;
  localparam int PATR_PAT_W   = 4;

  typedef enum logic [2:0] {
    POS_NONE = 3'd0,
    POS_1    = 3'd1,
    POS_2    = 3'd2,
    POS_3    = 3'd3,
    POS_4    = 3'd4,
    POS_5    = 3'd5
  } BitPosition_mne;

  typedef enum logic [1:0] {
    IDLE,
    HIT,
    MISS,
    DONE
  } PatrGenState_t;

endpackage

// File: rtl/patr_gen_next_pos.sv
// Priority encoder: lowest set mask position strictly above the current index.
module patr_next_pos
  import definitions::*;
#(
  parameter int NUM_POS = PATR_NUM_POS
) (
  input  logic [NUM_POS-1:0] mask,
  input  logic [2:0]         cur,
  output logic [2:0]         next_pos,
  output logic               none
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the loop leaves a latch.
    next_pos = POS_NONE;
    none     = 1'b1;
    // Scanning downward lets the lowest qualifying position win without a break.
    for (int k = NUM_POS; k >= 1; k--) begin
      if (k > int'(cur) && mask[k-1]) begin
        next_pos = 3'(k);
        none     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/patr_gen.sv
// Pattern stimulus generator: streams hit/miss bytes with expected-result tags over valid/ready.
module patr_gen
  import definitions::*;
#(
  parameter int NUM_POS = PATR_NUM_POS,
  parameter int PAT_W   = PATR_PAT_W,
  parameter int BYTE_W  = 8
) (
  input  logic               CLK,
  input  logic               RESET_n,
  input  logic               Start,
  input  logic [PAT_W-1:0]   PatrPattern,
  input  logic [NUM_POS-1:0] PosMask,
  input  logic               InsertMiss,
  output logic [BYTE_W-1:0]  GenData,
  output logic [2:0]         GenPos,
  output logic               GenHit,
  output logic               GenValid,
  input  logic               GenReady,
  output logic               Busy,
  output logic               Done,
  output logic [3:0]         ByteCount
);

  localparam logic [3:0] MAX_COUNT = 4'(2 * NUM_POS);

  PatrGenState_t      state;
  logic [PAT_W-1:0]   pat_q;
  logic [NUM_POS-1:0] mask_q;
  logic               miss_q;
  logic [2:0]         pos_q;

  logic [NUM_POS-1:0] enc_mask;
  logic [2:0]         enc_cur;
  logic [2:0]         nxt;
  logic               none;
  logic               xfer;

  function automatic logic [BYTE_W-1:0] place(logic [PAT_W-1:0] p, logic [2:0] k);
    return BYTE_W'(p) << (k - 3'd1);
  endfunction

  // In IDLE the encoder looks at the raw pins so the first position is ready at Start.
  assign enc_mask = (state == IDLE) ? PosMask : mask_q;
  assign enc_cur  = (state == IDLE) ? 3'd0    : pos_q;
  assign xfer     = GenValid & GenReady;
  assign Busy     = (state != IDLE);

  patr_next_pos #(.NUM_POS(NUM_POS)) u_next_pos (
    .mask     (enc_mask),
    .cur      (enc_cur),
    .next_pos (nxt),
    .none     (none)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= IDLE;
      pat_q     <= '0;
      mask_q    <= '0;
      miss_q    <= 1'b0;
      pos_q     <= POS_NONE;
      GenData   <= '0;
      GenPos    <= POS_NONE;
      GenHit    <= 1'b0;
      GenValid  <= 1'b0;
      Done      <= 1'b0;
      ByteCount <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            pat_q     <= PatrPattern;
            mask_q    <= PosMask;
            miss_q    <= InsertMiss;
            ByteCount <= '0;
            if (none) begin
              state <= DONE;
              Done  <= 1'b1;
            end else begin
              state    <= HIT;
              pos_q    <= nxt;
              GenValid <= 1'b1;
              GenData  <= place(PatrPattern, nxt);
              GenPos   <= nxt;
              GenHit   <= 1'b1;
            end
          end
        end
        HIT, MISS: begin
          if (xfer) begin
            if (ByteCount != MAX_COUNT) ByteCount <= 4'(ByteCount + 4'd1);
            if (state == HIT && miss_q) begin
              // An all-ones byte cannot hold a zero nibble; all-zeros cannot hold any other.
              state   <= MISS;
              GenData <= (pat_q == '0) ? '1 : '0;
              GenPos  <= POS_NONE;
              GenHit  <= 1'b0;
            end else if (none) begin
              state    <= DONE;
              Done     <= 1'b1;
              GenValid <= 1'b0;
              GenData  <= '0;
              GenPos   <= POS_NONE;
              GenHit   <= 1'b0;
            end else begin
              state   <= HIT;
              pos_q   <= nxt;
              GenData <= place(pat_q, nxt);
              GenPos  <= nxt;
              GenHit  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_patr_gen.sv
// Self-checking bench for patr_gen: directed vector table, hand sequences and randomized runs.
module tb_patr_gen;
  import definitions::*;

  logic       CLK = 1'b0;
  logic       RESET_n = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] PatrPattern = '0;
  logic [4:0] PosMask = '0;
  logic       InsertMiss = 1'b0;
  logic       GenReady = 1'b0;
  logic [7:0] GenData;
  logic [2:0] GenPos;
  logic       GenHit;
  logic       GenValid;
  logic       Busy;
  logic       Done;
  logic [3:0] ByteCount;

  patr_gen dut (
    .CLK         (CLK),
    .RESET_n     (RESET_n),
    .Start       (Start),
    .PatrPattern (PatrPattern),
    .PosMask     (PosMask),
    .InsertMiss  (InsertMiss),
    .GenData     (GenData),
    .GenPos      (GenPos),
    .GenHit      (GenHit),
    .GenValid    (GenValid),
    .GenReady    (GenReady),
    .Busy        (Busy),
    .Done        (Done),
    .ByteCount   (ByteCount)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] got_data[$];
  logic [2:0] got_pos[$];
  logic       got_hit[$];
  logic [7:0] exp_data[$];
  logic [2:0] exp_pos[$];
  logic       exp_hit[$];

  typedef struct {
    logic [3:0]        pat;
    logic [4:0]        mask;
    logic              miss;
    int                stall;
    int                n;
    logic [0:9][7:0]   data;
    logic [0:9][2:0]   pos;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural Patr: does the nibble appear in any of the five windows of the byte?
  function automatic logic patr_model(input logic [7:0] b, input logic [3:0] p);
    for (int k = 1; k <= 5; k++)
      if (b[k+2 -: 4] == p) return 1'b1;
    return 1'b0;
  endfunction

  task automatic build_exp(input logic [3:0] pat, input logic [4:0] mask, input logic miss);
    exp_data.delete(); exp_pos.delete(); exp_hit.delete();
    for (int k = 1; k <= 5; k++) begin
      if (mask[k-1]) begin
        exp_data.push_back(8'(int'(pat) * (1 << (k - 1))));
        exp_pos.push_back(3'(k));
        exp_hit.push_back(1'b1);
        if (miss) begin
          exp_data.push_back(pat == 4'h0 ? 8'hFF : 8'h00);
          exp_pos.push_back(3'd0);
          exp_hit.push_back(1'b0);
        end
      end
    end
  endtask

  task automatic run_seq(input logic [3:0] pat, input logic [4:0] mask, input logic miss,
                         input int stall, input int pct);
    logic [7:0] hd;
    logic [2:0] hp;
    logic       hh;
    bit         held;
    bit         finished;
    int         stalls_left;
    got_data.delete(); got_pos.delete(); got_hit.delete();
    @(negedge CLK);
    PatrPattern = pat; PosMask = mask; InsertMiss = miss; Start = 1'b1; GenReady = 1'b0;
    @(negedge CLK);
    check("start_valid", GenValid, mask != 5'd0);
    check("start_done", Done, mask == 5'd0);
    held = 1'b0; finished = 1'b0; stalls_left = stall;
    hd = '0; hp = '0; hh = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (cyc > 0) @(negedge CLK);
      if (held) begin
        check("stall_valid", GenValid, 1);
        check("stall_data", GenData, hd);
        check("stall_pos", GenPos, hp);
        check("stall_hit", GenHit, hh);
      end
      if (Done) begin
        check("done_busy", Busy, 1);
        check("done_valid", GenValid, 0);
        Start = 1'b0; GenReady = 1'b0; finished = 1'b1;
      end else begin
        // Mid-sequence pin noise, including Start, must be ignored.
        Start = 1'($urandom_range(0, 1));
        PatrPattern = 4'($urandom); PosMask = 5'($urandom); InsertMiss = 1'($urandom);
        if (!GenValid) begin
          check("valid_gap", GenValid, 1);
          GenReady = 1'($urandom_range(0, 1));
          held = 1'b0;
        end else begin
          if (stalls_left > 0) begin
            GenReady = 1'b0;
            stalls_left--;
          end else begin
            GenReady = ($urandom_range(0, 99) < pct);
          end
          if (GenReady) begin
            got_data.push_back(GenData);
            got_pos.push_back(GenPos);
            got_hit.push_back(GenHit);
            check("patr_out", patr_model(GenData, pat), GenHit);
          end
          held = !GenReady;
          hd = GenData; hp = GenPos; hh = GenHit;
        end
      end
    end
    if (!finished) check("seq_timeout", 0, 1);
    @(negedge CLK);
    check("done_pulse", Done, 0);
    check("idle_busy", Busy, 0);
    check("idle_valid", GenValid, 0);
    check("byte_count", ByteCount, got_data.size());
  endtask

  task automatic compare_exp(input string tag);
    check({tag, "_len"}, got_data.size(), exp_data.size());
    if (got_data.size() == exp_data.size()) begin
      for (int i = 0; i < exp_data.size(); i++) begin
        check({tag, "_data"}, got_data[i], exp_data[i]);
        check({tag, "_pos"}, got_pos[i], exp_pos[i]);
        check({tag, "_hit"}, got_hit[i], exp_hit[i]);
      end
    end
  endtask

  initial begin
    vecs[0] = '{pat: 4'hA, mask: 5'b11111, miss: 1'b1, stall: 0, n: 10,
                data: {8'h0A, 8'h00, 8'h14, 8'h00, 8'h28, 8'h00, 8'h50, 8'h00, 8'hA0, 8'h00},
                pos:  {3'd1, 3'd0, 3'd2, 3'd0, 3'd3, 3'd0, 3'd4, 3'd0, 3'd5, 3'd0}};
    vecs[1] = '{pat: 4'h0, mask: 5'b00100, miss: 1'b1, stall: 0, n: 2,
                data: {8'h00, 8'hFF, 64'h0}, pos: {3'd3, 3'd0, 24'd0}};
    vecs[2] = '{pat: 4'h9, mask: 5'b10010, miss: 1'b0, stall: 3, n: 2,
                data: {8'h12, 8'h90, 64'h0}, pos: {3'd2, 3'd5, 24'd0}};
    vecs[3] = '{pat: 4'hF, mask: 5'b00001, miss: 1'b1, stall: 0, n: 2,
                data: {8'h0F, 8'h00, 64'h0}, pos: {3'd1, 3'd0, 24'd0}};
    vecs[4] = '{pat: 4'h5, mask: 5'b10001, miss: 1'b1, stall: 1, n: 4,
                data: {8'h05, 8'h00, 8'h50, 8'h00, 48'h0}, pos: {3'd1, 3'd0, 3'd5, 3'd0, 18'd0}};
    vecs[5] = '{pat: 4'h3, mask: 5'b00000, miss: 1'b1, stall: 0, n: 0,
                data: 80'h0, pos: 30'd0};

    #1;
    check("rst_valid", GenValid, 0);
    check("rst_data", GenData, 0);
    check("rst_pos", GenPos, 0);
    check("rst_hit", GenHit, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_count", ByteCount, 0);
    repeat (2) @(negedge CLK);
    RESET_n = 1'b1;

    foreach (vecs[v]) begin
      run_seq(vecs[v].pat, vecs[v].mask, vecs[v].miss, vecs[v].stall, 100);
      check("vec_len", got_data.size(), vecs[v].n);
      if (got_data.size() == vecs[v].n) begin
        for (int i = 0; i < vecs[v].n; i++) begin
          check("vec_data", got_data[i], vecs[v].data[i]);
          check("vec_pos", got_pos[i], vecs[v].pos[i]);
          check("vec_hit", got_hit[i], vecs[v].pos[i] != 3'd0);
        end
      end
      @(negedge CLK);
      check("count_hold", ByteCount, vecs[v].n);
    end

    // Empty mask, then a Start held through the Done cycle must not launch a sequence.
    @(negedge CLK);
    PosMask = 5'b00000; PatrPattern = 4'h7; Start = 1'b1;
    @(negedge CLK);
    check("m0_done", Done, 1);
    check("m0_valid", GenValid, 0);
    PosMask = 5'b11111;
    @(negedge CLK);
    check("m0_done_once", Done, 0);
    check("m0_busy", Busy, 0);
    check("m0_count", ByteCount, 0);
    Start = 1'b0;
    @(negedge CLK);
    check("m0_ignored_valid", GenValid, 0);
    check("m0_ignored_busy", Busy, 0);

    // Asynchronous reset in the middle of a sequence.
    PatrPattern = 4'h6; PosMask = 5'b11111; InsertMiss = 1'b1; GenReady = 1'b1; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (3) @(negedge CLK);
    check("pre_rst_valid", GenValid, 1);
    #2 RESET_n = 1'b0;
    #1;
    check("arst_valid", GenValid, 0);
    check("arst_data", GenData, 0);
    check("arst_pos", GenPos, 0);
    check("arst_hit", GenHit, 0);
    check("arst_busy", Busy, 0);
    check("arst_done", Done, 0);
    check("arst_count", ByteCount, 0);
    @(negedge CLK);
    check("arst_no_done", Done, 0);
    RESET_n = 1'b1; GenReady = 1'b0;
    run_seq(4'h3, 5'b01100, 1'b0, 0, 100);
    build_exp(4'h3, 5'b01100, 1'b0);
    compare_exp("post_rst");

    for (int r = 0; r < 40; r++) begin
      logic [3:0] p;
      logic [4:0] m;
      logic       mi;
      p  = 4'($urandom);
      m  = 5'($urandom);
      mi = 1'($urandom);
      run_seq(p, m, mi, 0, 60);
      build_exp(p, m, mi);
      compare_exp("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/patr_gen.md
# patr_gen

Pattern stimulus generator: the producing end of the 4-bit pattern checker (`Patr`). It takes a 4-bit pattern and a set of bit positions. It then streams bytes over a valid/ready handshake, in ascending position order. Each byte carries the pattern at one position, optionally followed by a byte that is guaranteed not to contain it. Every byte is tagged with its position mnemonic and the expected checker result, so a downstream `Patr` instance can be driven and self-checked in hardware.

## Interface
- `NUM_POS`, 5: number of pattern positions in a byte (position k covers bits [k+2:k-1]).
- `PAT_W`, 4: pattern width.
- `BYTE_W`, 8: generated data width.

- `CLK`  in  1: clock, rising edge.
- `RESET_n`  in  1: asynchronous, active-low reset.
- `Start`  in  1: begin a sequence; sampled only in IDLE.
- `PatrPattern`  in  PAT_W: pattern to place; latched on accepted Start.
- `PosMask`  in  NUM_POS: bit k-1 set = emit position k; latched on accepted Start.
- `InsertMiss`  in  1: emit a miss byte after every hit byte; latched on accepted Start.
- `GenData`  out  BYTE_W: generated byte.
- `GenPos`  out  3 (`BitPosition_mne`): position of the pattern in `GenData`; `POS_NONE` (0) for miss bytes.
- `GenHit`  out  1: expected `PatrOut` for `GenData` against `PatrPattern`.
- `GenValid`  out  1: `GenData`/`GenPos`/`GenHit` valid.
- `GenReady`  in  1: consumer accepts the byte.
- `Busy`  out  1: state != IDLE.
- `Done`  out  1: one-cycle pulse at the end of a sequence.
- `ByteCount`  out  4: bytes transferred in the current or last sequence.

## Operation
- States are IDLE, HIT, MISS and DONE.
- **IDLE**
  - On `Start`=1: latch the inputs, clear `ByteCount`, and set the position index to the lowest set bit of `PosMask`.
  - Go to HIT, or to DONE if `PosMask`==0.
- **HIT**
  - Outputs: `GenValid`=1, `GenData` = `PatrPattern` << (k-1) with all other bits 0, `GenPos`=k, `GenHit`=1.
  - On transfer (`GenValid` & `GenReady`): if `InsertMiss`, go to MISS. Otherwise go to the next set mask bit above k (stay in HIT), or to DONE if there is none.
- **MISS**
  - Outputs: `GenValid`=1, `GenData` = 8'hFF if the pattern is 4'h0, else 8'h00, `GenPos`=`POS_NONE`, `GenHit`=0.
  - On transfer: go to the next set bit in HIT, or to DONE.
- **DONE**: `Done`=1 for exactly one cycle, then unconditionally go to IDLE.
- `ByteCount` increments on every transfer. The maximum is 10, with no wrap. It holds its value in IDLE until the next accepted `Start`.
- `Start` is ignored while `Busy`. The latched inputs are unaffected by changes on the input pins mid-sequence.
- While `GenValid`=1 and `GenReady`=0, all `Gen*` outputs hold stable; `GenValid` never drops without a transfer.
- Outside HIT and MISS, `GenValid`=0 and `GenData`/`GenPos`/`GenHit` are 0.

## Timing
- Reset values (asynchronous, while `RESET_n`=0):
  - state = IDLE.
  - `GenData`, `GenPos`, `GenHit`, `GenValid`, `Busy`, `Done` = 0.
  - `ByteCount` = 0.
  - Latched pattern, mask and miss flag = 0.
- Reset mid-sequence aborts immediately, with no `Done` pulse.
- `Start` is sampled at edge N, and `GenValid`=1 from cycle N+1.
- A transfer at edge M presents the next byte in cycle M+1, so back-to-back transfers are possible with `GenReady` held high.
- After the last transfer at edge M: `Done`=1 and `Busy`=1 in cycle M+1; `Busy`=0 from cycle M+2, when a new `Start` may be accepted.
- `PosMask`=0: `Start` at N gives `Done` in cycle N+1 with `ByteCount`=0.
- Outputs are registered or decoded from state only. There is no combinational path from `GenReady` or `Start` to any output.

## Structure
- The `definitions` package holds:
  - The existing `BitPosition_mne`, with `POS_NONE`=0 and positions 1..5.
  - New `PatrGenState_t` (IDLE/HIT/MISS/DONE).
  - Constants `PATR_NUM_POS`=5 and `PATR_PAT_W`=4.
- Sub-module `patr_next_pos`: a combinational priority encoder. Given the mask and the current index, it returns the next set position above it, plus a none-left flag. It is used at Start and on each advance.

## Test plan
- Pattern 4'b1010, mask 5'b11111, `InsertMiss`=1, `GenReady`=1 → bytes 0A,00,14,00,28,00,50,00,A0,00 with `GenHit` alternating 1/0, `GenPos` 1,0,2,0,…,5,0; `ByteCount`=10; one `Done` pulse.
- Pattern 4'h0, mask 5'b00100, `InsertMiss`=1 → bytes 00 (pos 3, hit) then FF (pos 0, hit 0).
- Mask 5'b10010, `InsertMiss`=0, `GenReady` low for 3 cycles on the first byte → byte 0x?<<1 held stable for the full stall; then pos 5 byte; `ByteCount`=2.
- Mask 0 → `Done` in the cycle after `Start`, no `GenValid`; a second `Start` while `Busy` is ignored.
- `RESET_n` low mid-sequence → all outputs 0 asynchronously, no `Done`; the next `Start` restarts from the lowest position.
- Every generated byte is fed into a `Patr` instance with `PatrSrcB` = pattern → `PatrOut` equals `GenHit` on every transfer.
